m_d_areg_tx: RTL and testbench

Memory-to-d-side response transmitter.
- Captures one full memory response message (176 bits) when memory signals a completed access.
- Serializes the message MSB-first into 16-bit flits toward the d-side ring interface, using a valid/ready handshake.
- Exposes a busy state so the memory controller does not issue a second response while one is in flight.

---
 rtl/m_d_areg_tx_pkg.sv | 16 +
 rtl/m_d_areg_tx.sv | 95 +++++++++
 tb/tb_m_d_areg_tx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/m_d_areg_tx_pkg.sv
// Shared constants for the memory -> d-side response transmitter.
package m_d_areg_tx_pkg;
  localparam int FLIT_W    = 16;
  localparam int MSG_W     = 176;
  localparam int NUM_FLITS = MSG_W / FLIT_W;
  localparam int CNT_W     = 4;

  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b00;
  localparam logic [1:0] CTRL_TAIL = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;
endpackage

// File: rtl/m_d_areg_tx.sv
// Captures a 176-bit memory response and streams it MSB-first as 16-bit
// flits over a valid/ready link. Busy while a message is held.
module m_d_areg_tx
  import m_d_areg_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MSG_W-1:0]  m_flits_d,
  input  logic              v_m_flits_d,
  input  logic              flush,
  input  logic              d_rdy_m,
  output logic [FLIT_W-1:0] m_d_flit,
  output logic              v_m_d_flit,
  output logic [1:0]        m_d_ctrl,
  output logic              m_d_areg_state,
  output logic              m_d_tx_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FLITS - 1);

  // Message held as flit slots; slot NUM_FLITS-1 is the MSB flit (sent first).
  tx_state_e                        state_q, state_d;
  logic [NUM_FLITS-1:0][FLIT_W-1:0] msg_q, msg_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             done_q, done_d;
  logic [CNT_W-1:0]                 slot;

  // Next-state: flush beats handshake and load; loads only accepted in IDLE.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (flush) begin
      state_d = IDLE;
      msg_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (v_m_flits_d) begin
            msg_d   = m_flits_d;
            cnt_d   = '0;
            state_d = SEND;
          end
        end
        SEND: begin
          if (d_rdy_m) begin
            if (cnt_q == LAST) begin
              state_d = IDLE;
              msg_d   = '0;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, message, counter and done pulse registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      msg_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Slice mux: flit/ctrl/valid derived from held message and counter only,
  // so they stay stable while the receiver stalls.
  always_comb begin
    slot           = LAST - cnt_q;
    v_m_d_flit     = (state_q == SEND);
    m_d_flit       = '0;
    m_d_ctrl       = CTRL_BODY;
    if (state_q == SEND) begin
      m_d_flit = msg_q[slot];
      if (cnt_q == '0)       m_d_ctrl = CTRL_HEAD;
      else if (cnt_q == LAST) m_d_ctrl = CTRL_TAIL;
    end
    m_d_areg_state = (state_q == SEND);
    m_d_tx_done    = done_q;
  end

endmodule

// File: tb/tb_m_d_areg_tx.sv
// Directed bench for m_d_areg_tx: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_m_d_areg_tx;
  import m_d_areg_tx_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [MSG_W-1:0]  m_flits_d;
  logic              v_m_flits_d;
  logic              flush;
  logic              d_rdy_m;
  logic [FLIT_W-1:0] m_d_flit;
  logic              v_m_d_flit;
  logic [1:0]        m_d_ctrl;
  logic              m_d_areg_state;
  logic              m_d_tx_done;

  int n_asrt = 0;
  int n_fail = 0;

  m_d_areg_tx dut (
    .clk(clk), .rst(rst), .m_flits_d(m_flits_d), .v_m_flits_d(v_m_flits_d),
    .flush(flush), .d_rdy_m(d_rdy_m), .m_d_flit(m_d_flit),
    .v_m_d_flit(v_m_d_flit), .m_d_ctrl(m_d_ctrl),
    .m_d_areg_state(m_d_areg_state), .m_d_tx_done(m_d_tx_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(v_m_d_flit), 32'd0);
    chk({tag, " flit"},  32'(m_d_flit), 32'd0);
    chk({tag, " ctrl"},  32'(m_d_ctrl), 32'd0);
    chk({tag, " state"}, 32'(m_d_areg_state), 32'd0);
  endtask

  function automatic logic [1:0] exp_ctrl(input int i);
    if (i == 0) return 2'b01;
    if (i == NUM_FLITS - 1) return 2'b10;
    return 2'b00;
  endfunction

  logic [MSG_W-1:0] msg_a, msg_b, msg_f;
  int k;

  initial begin
    for (int i = 0; i < NUM_FLITS; i++) begin
      msg_a[MSG_W-1-i*FLIT_W -: FLIT_W] = 16'h0A00 + 16'(i);
      msg_b[MSG_W-1-i*FLIT_W -: FLIT_W] = 16'h0B00 + 16'(i);
    end
    msg_f = '1;

    // Reset then idle
    rst = 1'b0; m_flits_d = '0; v_m_flits_d = 1'b0; flush = 1'b0; d_rdy_m = 1'b0;
    tick(); tick();
    chk_idle("reset");
    chk("reset done", 32'(m_d_tx_done), 32'd0);
    rst = 1'b1;
    tick();
    chk_idle("idle");

    // Full message, ready always high
    m_flits_d = msg_a; v_m_flits_d = 1'b1; d_rdy_m = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    for (int i = 0; i < NUM_FLITS; i++) begin
      chk($sformatf("stream flit%0d", i), 32'(m_d_flit), 32'(16'h0A00 + 16'(i)));
      chk($sformatf("stream ctrl%0d", i), 32'(m_d_ctrl), 32'(exp_ctrl(i)));
      chk($sformatf("stream vld%0d", i), 32'(v_m_d_flit), 32'd1);
      chk($sformatf("stream busy%0d", i), 32'(m_d_areg_state), 32'd1);
      tick();
    end
    chk("stream done", 32'(m_d_tx_done), 32'd1);
    chk_idle("stream end");
    tick();
    chk("stream done pulse width", 32'(m_d_tx_done), 32'd0);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    m_flits_d = msg_a; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < NUM_FLITS; c++) begin
      d_rdy_m = (c % 3 == 0);
      chk($sformatf("bp flit c%0d", c), 32'(m_d_flit), 32'(16'h0A00 + 16'(k)));
      chk($sformatf("bp ctrl c%0d", c), 32'(m_d_ctrl), 32'(exp_ctrl(k)));
      chk($sformatf("bp done c%0d", c), 32'(m_d_tx_done), 32'd0);
      tick();
      if (d_rdy_m) k++;
    end
    chk("bp transfers", 32'(k), 32'(NUM_FLITS));
    chk("bp done", 32'(m_d_tx_done), 32'd1);
    chk("bp state", 32'(m_d_areg_state), 32'd0);
    d_rdy_m = 1'b1;
    tick();

    // Load while sending is ignored
    m_flits_d = msg_a; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    tick(); tick(); tick();
    m_flits_d = msg_f; v_m_flits_d = 1'b1;
    chk("ovl flit3", 32'(m_d_flit), 32'h0A03);
    tick();
    v_m_flits_d = 1'b0;
    for (int i = 4; i < NUM_FLITS; i++) begin
      chk($sformatf("ovl flit%0d", i), 32'(m_d_flit), 32'(16'h0A00 + 16'(i)));
      tick();
    end
    chk("ovl done", 32'(m_d_tx_done), 32'd1);
    chk_idle("ovl end");
    tick();

    // Flush at flit 5, then reload
    m_flits_d = msg_a; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    repeat (5) tick();
    chk("flush pre flit5", 32'(m_d_flit), 32'h0A05);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_idle("flush");
    chk("flush no done", 32'(m_d_tx_done), 32'd0);
    m_flits_d = msg_b; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    chk("reload head", 32'(m_d_flit), 32'h0B00);
    chk("reload ctrl", 32'(m_d_ctrl), 32'h1);
    chk("reload no done", 32'(m_d_tx_done), 32'd0);
    repeat (NUM_FLITS) tick();
    chk("reload done", 32'(m_d_tx_done), 32'd1);
    tick();

    // Flush in IDLE suppresses a same-cycle load
    m_flits_d = msg_a; v_m_flits_d = 1'b1; flush = 1'b1;
    tick();
    v_m_flits_d = 1'b0; flush = 1'b0;
    chk_idle("idle flush");

    // Reset mid-message at flit 7
    m_flits_d = msg_a; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    repeat (7) tick();
    chk("rst pre flit7", 32'(m_d_flit), 32'h0A07);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_idle("mid rst");
    chk("mid rst done", 32'(m_d_tx_done), 32'd0);
    tick();
    chk("mid rst done later", 32'(m_d_tx_done), 32'd0);
    m_flits_d = msg_b; v_m_flits_d = 1'b1;
    tick();
    v_m_flits_d = 1'b0;
    chk("post rst head", 32'(m_d_flit), 32'h0B00);
    chk("post rst ctrl", 32'(m_d_ctrl), 32'h1);
    repeat (NUM_FLITS - 1) tick();
    chk("post rst tail", 32'(m_d_flit), 32'h0B0A);
    chk("post rst tail ctrl", 32'(m_d_ctrl), 32'h2);
    tick();
    chk("post rst done", 32'(m_d_tx_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
